// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake into a
// one-entry buffer feeding the F/D register, and applies decode-stage redirects.
module fetch_stage #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   StallF,
  input  logic                   PCSrcD,
  input  logic [ADDR_WIDTH-1:0]  PCBranchD,
  input  logic                   JumpD,
  input  logic [ADDR_WIDTH-1:0]  PCJumpD,
  output logic                   IMem_Req,
  output logic [ADDR_WIDTH-1:0]  IMem_Addr,
  input  logic                   IMem_Ready,
  input  logic [INSTR_WIDTH-1:0] IMem_RData,
  output logic [INSTR_WIDTH-1:0] InstrF,
  output logic [ADDR_WIDTH-1:0]  PCPlus4F,
  output logic                   ValidF,
  output logic                   FetchBusyF,
  output logic [ADDR_WIDTH-1:0]  PCF
);

  // Handshake: a transfer completes on any rising edge where IMem_Req && IMem_Ready;
  // IMem_Addr is held stable while IMem_Req=1 until that edge, and IMem_Ready is
  // ignored when IMem_Req=0. Ready may arrive in the same cycle as Req.

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                   state_q, state_n;
  logic [ADDR_WIDTH-1:0]    pc_q, pc_n;
  logic [ADDR_WIDTH-1:0]    pend_q, pend_n;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_n;
  logic [ADDR_WIDTH-1:0]    pcplus4_q, pcplus4_n;
  logic                     valid_q, valid_n;

  logic                     redirect;
  logic [ADDR_WIDTH-1:0]    target;
  logic [ADDR_WIDTH-1:0]    pc_inc;

  assign redirect = !StallF && (JumpD || PCSrcD);
  assign target   = JumpD ? PCJumpD : PCBranchD;
  assign pc_inc   = pc_q + ADDR_WIDTH'(4);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      pend_q    <= '0;
      instr_q   <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      pc_q      <= pc_n;
      pend_q    <= pend_n;
      instr_q   <= instr_n;
      pcplus4_q <= pcplus4_n;
      valid_q   <= valid_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    pend_n    = pend_q;
    instr_n   = instr_q;
    pcplus4_n = pcplus4_q;
    valid_n   = valid_q;
    case (state_q)
      S_REQ: begin
        if (IMem_Ready) begin
          if (redirect) begin
            pc_n = target;
          end else begin
            instr_n   = IMem_RData;
            pcplus4_n = pc_inc;
            valid_n   = 1'b1;
            pc_n      = pc_inc;
            state_n   = S_HOLD;
          end
        end else if (redirect) begin
          pend_n  = target;
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The old request must complete before the redirected address can be issued.
        if (IMem_Ready) begin
          pc_n    = redirect ? target : pend_q;
          pend_n  = '0;
          state_n = S_REQ;
        end else if (redirect) begin
          pend_n = target;
        end
      end
      S_HOLD: begin
        if (!StallF) begin
          valid_n = 1'b0;
          state_n = S_REQ;
          if (redirect) pc_n = target;
        end
      end
      default: begin
        state_n = S_REQ;
        valid_n = 1'b0;
      end
    endcase
  end

  assign FetchBusyF = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign IMem_Req   = RST && FetchBusyF;
  assign IMem_Addr  = pc_q;
  assign PCF        = pc_q;
  assign ValidF     = valid_q;
  assign InstrF     = valid_q ? instr_q : '0;
  assign PCPlus4F   = valid_q ? pcplus4_q : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of fetch/present/redirect behaviour.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        CLK, RST;
  logic        StallF, PCSrcD, JumpD, IMem_Ready;
  logic [31:0] PCBranchD, PCJumpD, IMem_RData;
  logic        IMem_Req, ValidF, FetchBusyF;
  logic [31:0] IMem_Addr, InstrF, PCPlus4F, PCF;

  fetch_stage #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RPC)) dut (
    .CLK(CLK), .RST(RST), .StallF(StallF), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .JumpD(JumpD), .PCJumpD(PCJumpD), .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
    .IMem_Ready(IMem_Ready), .IMem_RData(IMem_RData), .InstrF(InstrF),
    .PCPlus4F(PCPlus4F), .ValidF(ValidF), .FetchBusyF(FetchBusyF), .PCF(PCF)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // scoreboard: presented {PCPlus4, instr} pairs still owed to F/D
  logic [63:0] exp_q[$];

  // model: address the next fetch must use, whether an instruction is being
  // presented, and whether the current transaction has been overtaken by a redirect
  logic [31:0] m_addr;
  logic [31:0] m_tgt;
  bit          m_present;
  bit          m_taint;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr    = RPC;
    m_tgt     = '0;
    m_present = 1'b0;
    m_taint   = 1'b0;
    exp_q.delete();
  endtask

  // drive one cycle of inputs, check outputs, advance the model across the next edge
  task automatic step(input bit stall, input bit br, input logic [31:0] btgt,
                      input bit jp, input logic [31:0] jtgt, input bit rdy);
    bit          redir;
    logic [31:0] tgt;
    logic [63:0] head;
    @(negedge CLK);
    StallF     = stall;
    PCSrcD     = br;
    PCBranchD  = btgt;
    JumpD      = jp;
    PCJumpD    = jtgt;
    IMem_Ready = rdy;
    IMem_RData = rdy ? word(IMem_Addr) : $urandom;
    #1;
    redir = !stall && (br || jp);
    tgt   = jp ? jtgt : btgt;
    check("pcf", {32'd0, PCF}, {32'd0, m_addr});
    if (!m_present) begin
      check("req_fetch", {63'd0, IMem_Req}, 64'd1);
      check("busy_fetch", {63'd0, FetchBusyF}, 64'd1);
      check("addr", {32'd0, IMem_Addr}, {32'd0, m_addr});
      check("valid_fetch", {63'd0, ValidF}, 64'd0);
      check("nop_out", {PCPlus4F, InstrF}, 64'd0);
      if (redir) begin
        m_taint = 1'b1;
        m_tgt   = tgt;
      end
      if (rdy) begin
        if (m_taint) begin
          m_addr  = m_tgt;
          m_taint = 1'b0;
        end else begin
          exp_q.push_back({m_addr + 32'd4, word(m_addr)});
          m_addr    = m_addr + 32'd4;
          m_present = 1'b1;
        end
      end
    end else begin
      head = (exp_q.size() > 0) ? exp_q[0] : 64'hx;
      check("req_hold", {63'd0, IMem_Req}, 64'd0);
      check("busy_hold", {63'd0, FetchBusyF}, 64'd0);
      check("valid_hold", {63'd0, ValidF}, 64'd1);
      check("instr_pc4", {PCPlus4F, InstrF}, head);
      if (!stall) begin
        void'(exp_q.pop_front());
        m_present = 1'b0;
        if (redir) m_addr = tgt;
      end
    end
  endtask

  task automatic plain(input bit rdy);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, rdy);
  endtask

  task automatic to_present();
    for (int i = 0; i < 16 && !m_present; i++) plain(1'b1);
    check("reach_present", {63'd0, m_present}, 64'd1);
  endtask

  task automatic to_fetch();
    for (int i = 0; i < 16 && m_present; i++) plain(1'b0);
    check("reach_fetch", {63'd0, m_present}, 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("rst_req", {63'd0, IMem_Req}, 64'd0);
    check("rst_pcf", {32'd0, PCF}, {32'd0, RPC});
    check("rst_out", {31'd0, ValidF, PCPlus4F, InstrF}, 64'd0);
    model_reset();
    @(posedge CLK);
    #2;
    check("rst_req_hold", {63'd0, IMem_Req}, 64'd0);
    RST = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // driver / scenario sequence
  initial begin
    RST = 1'b0; StallF = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0; IMem_Ready = 1'b0;
    PCBranchD = '0; PCJumpD = '0; IMem_RData = '0;
    model_reset();
    #12;
    check("reset_req", {63'd0, IMem_Req}, 64'd0);
    check("reset_pcf", {32'd0, PCF}, {32'd0, RPC});
    check("reset_out", {31'd0, ValidF, PCPlus4F, InstrF}, 64'd0);
    @(posedge CLK);
    #2;
    RST = 1'b1;

    // zero-wait fetch of 0 and 4 (each fetch then present)
    repeat (4) plain(1'b1);
    // address 8 with ready delayed 3 cycles
    repeat (3) plain(1'b0);
    plain(1'b1);
    plain(1'b1);
    // zero-wait 0xC, then hold 0x10 stalled for 5 cycles
    plain(1'b1); plain(1'b1);
    plain(1'b1);
    repeat (5) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    plain(1'b1);
    check("after_stall_addr", {32'd0, m_addr}, 64'h14);
    // walk to 0x20 held, then branch out of hold
    while (m_addr != 32'h24 || !m_present) plain(1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0);
    // jump while 0x100 is outstanding; ready after 2 cycles
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h400, 1'b0);
    plain(1'b0);
    plain(1'b1);
    // branch + jump together on a zero-wait fetch: jump wins
    step(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
    // same redirect under stall is ignored
    step(1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
    to_fetch();
    // redirect overwritten while draining, then one on the ready cycle
    step(1'b0, 1'b1, 32'h500, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h600, 1'b0);
    plain(1'b1);
    step(1'b0, 1'b1, 32'h700, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 32'h800, 1'b0, 32'd0, 1'b1);
    // PC+4 wraps at the top of the address space
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    to_present();
    check("wrap_pc4", {32'd0, PCPlus4F}, 64'd0);
    plain(1'b0);
    // reset in the middle of an outstanding request
    plain(1'b0);
    pulse_reset();
    plain(1'b1);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 4) < 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
